// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared constants and helpers for the sram-like arbiter
package sram_like_pkg;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR = 1;
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/id_fifo.sv
// id_fifo: in-order FIFO of issuing channel IDs for outstanding transactions
module id_fifo #(
   parameter int W = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic                     full,
   output logic                     empty,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   assign count = wptr - rptr;
   assign empty = wptr == rptr;
   assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head = mem[rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges CH_NUM request channels onto one sram-like bus with in-order response routing
module sram_like_arbiter
   import sram_like_pkg::*;
#(
   parameter int CH_NUM = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int OUTSTANDING = 4,
   parameter int ARB_MODE = 0
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [CH_NUM-1:0]        ch_req,
   input  logic [CH_NUM-1:0]        ch_wr,
   input  logic [2*CH_NUM-1:0]      ch_size,
   input  logic [ADDR_W*CH_NUM-1:0] ch_addr,
   input  logic [DATA_W*CH_NUM-1:0] ch_wdata,
   output logic [CH_NUM-1:0]        ch_addr_ok,
   output logic [CH_NUM-1:0]        ch_data_ok,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic                     m_req,
   output logic                     m_wr,
   output logic [1:0]               m_size,
   output logic [ADDR_W-1:0]        m_addr,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic                     m_addr_ok,
   input  logic                     m_data_ok,
   input  logic [DATA_W-1:0]        m_rdata,
   output logic                     busy,
   output logic                     err_spurious
);
   localparam int IW = id_w(CH_NUM);
   localparam int CW = $clog2(OUTSTANDING) + 1;
   localparam logic [IW-1:0] LAST = IW'(CH_NUM - 1);
   localparam logic [CH_NUM-1:0] ONE = {{(CH_NUM-1){1'b0}}, 1'b1};
   logic [IW-1:0] rr_ptr, lock_id, pick, grant, head;
   logic lock_valid, full, empty, accept, pop, found;
   logic [CW-1:0] count;
   int j;
   always_comb begin
      pick = '0;
      found = 1'b0;
      j = 0;
      for (int k = 0; k < CH_NUM; k++) begin
         j = (ARB_MODE == ARB_RR) ? (int'(rr_ptr) + k) % CH_NUM : k;
         if (!found && ch_req[j]) begin
            found = 1'b1;
            pick = j[IW-1:0];
         end
      end
   end
   // a stalled request keeps its grant so the bus fields stay stable until accepted
   assign grant = lock_valid ? lock_id : pick;
   assign m_req = resetn & (lock_valid | (|ch_req)) & (~full | m_data_ok);
   assign m_wr = ch_wr[grant];
   assign m_size = ch_size[2*int'(grant) +: 2];
   assign m_addr = ch_addr[ADDR_W*int'(grant) +: ADDR_W];
   assign m_wdata = ch_wdata[DATA_W*int'(grant) +: DATA_W];
   assign accept = m_req & m_addr_ok;
   assign pop = m_data_ok & ~empty;
   assign ch_addr_ok = accept ? ONE << grant : '0;
   assign ch_data_ok = pop ? ONE << head : '0;
   assign ch_rdata = m_rdata;
   assign busy = count != '0;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lock_valid <= 1'b0;
         lock_id <= '0;
         rr_ptr <= '0;
         err_spurious <= 1'b0;
      end else begin
         lock_valid <= m_req & ~m_addr_ok;
         if (m_req) lock_id <= grant;
         if (accept) rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
         if (m_data_ok & empty) err_spurious <= 1'b1;
      end
   end
   id_fifo #(.W(IW), .DEPTH(OUTSTANDING)) u_fifo (
      .clk(clk), .resetn(resetn), .push(accept), .pop(pop), .din(grant),
      .full(full), .empty(empty), .head(head), .count(count)
   );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: fixed-priority and round-robin instances against a queue-based model
module tb_sram_like_arbiter;
   logic clk = 1'b0;
   logic resetn;
   logic [1:0] ch_req, ch_wr;
   logic [3:0] ch_size;
   logic [63:0] ch_addr, ch_wdata;
   logic m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;
   logic [1:0] aok [2];
   logic [1:0] dok [2];
   logic [1:0] msz [2];
   logic [31:0] rdat [2];
   logic [31:0] maddr [2];
   logic [31:0] mwd [2];
   logic mreq [2];
   logic mwr [2];
   logic bsy [2];
   logic errs [2];
   int n_chk = 0, n_fail = 0;
   bit en = 1'b0;
   int q0 [$];
   int q1 [$];
   int rr [2] = '{0, 0};
   bit lkv [2] = '{0, 0};
   int lki [2] = '{0, 0};
   bit er [2] = '{0, 0};
   int n, c, hd;
   bit ereq, epop;
   logic [1:0] eaok, edok;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_like_arbiter #(.CH_NUM(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4), .ARB_MODE(g)) u_dut (
         .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
         .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(aok[g]), .ch_data_ok(dok[g]),
         .ch_rdata(rdat[g]), .m_req(mreq[g]), .m_wr(mwr[g]), .m_size(msz[g]), .m_addr(maddr[g]),
         .m_wdata(mwd[g]), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
         .busy(bsy[g]), .err_spurious(errs[g])
      );
   end

   task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s u%0d: got %h expected %h", nm, u, act, exp);
      end
   endtask

   function automatic int qn(input int m);
      return m != 0 ? q1.size() : q0.size();
   endfunction
   function automatic int qh(input int m);
      return m != 0 ? q1[0] : q0[0];
   endfunction
   function automatic void qpush(input int m, input int v);
      if (m != 0) q1.push_back(v); else q0.push_back(v);
   endfunction
   function automatic void qpop(input int m);
      if (m != 0) void'(q1.pop_front()); else void'(q0.pop_front());
   endfunction
   function automatic void qclr(input int m);
      if (m != 0) q1.delete(); else q0.delete();
   endfunction
   function automatic int pick(input int mode, input int p, input logic [1:0] req);
      for (int k = 0; k < 2; k++) begin
         int x;
         x = (mode != 0) ? (p + k) % 2 : k;
         if (req[x]) return x;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (en) begin
         for (int m = 0; m < 2; m++) begin
            n = qn(m);
            hd = (n > 0) ? qh(m) : 0;
            c = lkv[m] ? lki[m] : pick(m, rr[m], ch_req);
            ereq = resetn && (lkv[m] || ch_req != 2'b00) && (n < 4 || m_data_ok);
            eaok = (ereq && m_addr_ok) ? 2'(1 << c) : 2'b00;
            epop = m_data_ok && n > 0;
            edok = epop ? 2'(1 << hd) : 2'b00;
            chk("m_req", m, 32'(mreq[m]), 32'(ereq));
            chk("ch_addr_ok", m, 32'(aok[m]), 32'(eaok));
            chk("ch_data_ok", m, 32'(dok[m]), 32'(edok));
            chk("busy", m, 32'(bsy[m]), 32'(n != 0));
            chk("err_spurious", m, 32'(errs[m]), 32'(er[m]));
            if (ereq) begin
               chk("m_addr", m, maddr[m], ch_addr[c*32 +: 32]);
               chk("m_wdata", m, mwd[m], ch_wdata[c*32 +: 32]);
               chk("m_wr", m, 32'(mwr[m]), 32'(ch_wr[c]));
               chk("m_size", m, 32'(msz[m]), 32'(ch_size[c*2 +: 2]));
            end
            if (epop) chk("ch_rdata", m, rdat[m], m_rdata);
            if (!resetn) begin
               qclr(m);
               rr[m] = 0;
               lkv[m] = 1'b0;
               er[m] = 1'b0;
            end else begin
               if (epop) qpop(m);
               if (ereq && m_addr_ok) begin
                  qpush(m, c);
                  lkv[m] = 1'b0;
                  rr[m] = (c + 1) % 2;
               end else if (ereq) begin
                  lkv[m] = 1'b1;
                  lki[m] = c;
               end
               if (m_data_ok && n == 0) er[m] = 1'b1;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic both(input string nm, input logic [31:0] a0, input logic [31:0] e0, input logic [31:0] a1, input logic [31:0] e1);
      chk(nm, 0, a0, e0);
      chk(nm, 1, a1, e1);
   endtask

   initial begin
      resetn = 1'b0; ch_req = 2'b00; ch_wr = 2'b01; ch_size = 4'b0110;
      ch_addr = {32'h1000, 32'h2000}; ch_wdata = {32'hD1, 32'hD0};
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
      cyc(); en = 1'b1;
      cyc();
      both("rst_m_req", 32'(mreq[0]), 0, 32'(mreq[1]), 0);
      both("rst_busy", 32'(bsy[0]), 0, 32'(bsy[1]), 0);
      both("rst_err", 32'(errs[0]), 0, 32'(errs[1]), 0);
      resetn = 1'b1;
      // priority versus round-robin with both channels requesting
      cyc(); ch_req = 2'b11; m_addr_ok = 1'b1; #1;
      both("arb_c1", 32'(aok[0]), 32'b01, 32'(aok[1]), 32'b01);
      cyc();
      both("arb_c2", 32'(aok[0]), 32'b01, 32'(aok[1]), 32'b10);
      cyc(); ch_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h11; #1;
      both("arb_rsp1", 32'(dok[0]), 32'b01, 32'(dok[1]), 32'b01);
      cyc(); m_rdata = 32'h22; #1;
      both("arb_rsp2", 32'(dok[0]), 32'b01, 32'(dok[1]), 32'b10);
      // grant lock: ch1 stalled, ch0 arrives later and must wait
      cyc(); m_data_ok = 1'b0; ch_req = 2'b10; #1;
      both("lock_addr1", maddr[0], 32'h1000, maddr[1], 32'h1000);
      cyc(); ch_req = 2'b11; #1;
      both("lock_addr2", maddr[0], 32'h1000, maddr[1], 32'h1000);
      cyc(); #1;
      both("lock_addr3", maddr[0], 32'h1000, maddr[1], 32'h1000);
      cyc(); m_addr_ok = 1'b1; #1;
      both("lock_acc", 32'(aok[0]), 32'b10, 32'(aok[1]), 32'b10);
      cyc(); ch_req = 2'b01; #1;
      both("lock_next", maddr[0], 32'h2000, maddr[1], 32'h2000);
      cyc(); ch_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b1; #1;
      both("lock_rsp1", 32'(dok[0]), 32'b10, 32'(dok[1]), 32'b10);
      cyc(); #1;
      both("lock_rsp2", 32'(dok[0]), 32'b01, 32'(dok[1]), 32'b01);
      // fill to OUTSTANDING, then a response frees a slot in the same cycle
      cyc(); m_data_ok = 1'b0; ch_req = 2'b01; m_addr_ok = 1'b1;
      repeat (4) cyc();
      both("full_mreq", 32'(mreq[0]), 0, 32'(mreq[1]), 0);
      both("full_busy", 32'(bsy[0]), 1, 32'(bsy[1]), 1);
      m_data_ok = 1'b1; #1;
      both("full_pass_req", 32'(mreq[0]), 1, 32'(mreq[1]), 1);
      both("full_pass_aok", 32'(aok[0]), 32'b01, 32'(aok[1]), 32'b01);
      cyc(); m_data_ok = 1'b0; #1;
      both("full_again", 32'(mreq[0]), 0, 32'(mreq[1]), 0);
      ch_req = 2'b00; m_data_ok = 1'b1;
      repeat (4) cyc();
      // in-order routing of IDs 1,0,1
      m_data_ok = 1'b0; ch_req = 2'b10; m_addr_ok = 1'b1;
      cyc(); ch_req = 2'b01;
      cyc(); ch_req = 2'b10;
      cyc(); ch_req = 2'b00; m_data_ok = 1'b1; m_rdata = 32'hA; #1;
      both("id_dok1", 32'(dok[0]), 32'b10, 32'(dok[1]), 32'b10);
      both("id_rd1", rdat[0], 32'hA, rdat[1], 32'hA);
      cyc(); m_rdata = 32'hB; #1;
      both("id_dok2", 32'(dok[0]), 32'b01, 32'(dok[1]), 32'b01);
      both("id_rd2", rdat[0], 32'hB, rdat[1], 32'hB);
      cyc(); m_rdata = 32'hC; #1;
      both("id_dok3", 32'(dok[0]), 32'b10, 32'(dok[1]), 32'b10);
      both("id_rd3", rdat[0], 32'hC, rdat[1], 32'hC);
      // spurious response while idle
      cyc(); #1;
      both("spur_dok", 32'(dok[0]), 0, 32'(dok[1]), 0);
      both("spur_err0", 32'(errs[0]), 0, 32'(errs[1]), 0);
      cyc(); m_data_ok = 1'b0; #1;
      both("spur_err1", 32'(errs[0]), 1, 32'(errs[1]), 1);
      repeat (40) begin
         cyc();
         ch_req = 2'($urandom_range(0, 3));
         ch_wr = 2'($urandom_range(0, 3));
         ch_size = 4'($urandom_range(0, 15));
         ch_addr = {$urandom, $urandom};
         ch_wdata = {$urandom, $urandom};
         m_addr_ok = 1'($urandom_range(0, 1));
         m_data_ok = 1'($urandom_range(0, 1));
         m_rdata = $urandom;
      end
      // reset in the middle of traffic
      cyc(); ch_req = 2'b01; m_addr_ok = 1'b1; m_data_ok = 1'b0;
      cyc(); resetn = 1'b0; #1;
      both("rst_mid_mreq", 32'(mreq[0]), 0, 32'(mreq[1]), 0);
      both("rst_mid_aok", 32'(aok[0]), 0, 32'(aok[1]), 0);
      both("rst_mid_busy", 32'(bsy[0]), 1, 32'(bsy[1]), 1);
      cyc(); resetn = 1'b1; ch_req = 2'b00; m_addr_ok = 1'b0; #1;
      both("post_rst_busy", 32'(bsy[0]), 0, 32'(bsy[1]), 0);
      both("post_rst_err", 32'(errs[0]), 0, 32'(errs[1]), 0);
      both("post_rst_dok", 32'(dok[0]), 0, 32'(dok[1]), 0);
      cyc(); cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter that merges the CPU's per-stage memory request channels (instruction fetch, data access, and further masters) onto a single sram-like bus with `req`/`addr_ok`/`data_ok` handshakes. It is the successor to the fixed, single-cycle `inst_sram`/`data_sram` port pair. It supports a configurable channel count, a selectable arbitration mode and multiple outstanding transactions. Responses are returned in order and routed back to the issuing channel through an internal ID FIFO. The block sits between the CPU top and the cache/AXI bridge.

## Interface
- `CH_NUM`, 2, number of request channels (2..8); channel 0 = data, channel 1 = inst by integration convention.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `OUTSTANDING`, 4, maximum accepted-but-unanswered transactions (power of two, 2..16).
- `ARB_MODE`, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- `clk`  in  1  single clock, all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `ch_req`  in  CH_NUM  per-channel request.
- `ch_wr`  in  CH_NUM  per-channel write flag.
- `ch_size`  in  2*CH_NUM  per-channel size, 0 = byte, 1 = half, 2 = word.
- `ch_addr`  in  ADDR_W*CH_NUM  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W].
- `ch_wdata`  in  DATA_W*CH_NUM  per-channel write data.
- `ch_addr_ok`  out  CH_NUM  request accepted this cycle.
- `ch_data_ok`  out  CH_NUM  response for this channel this cycle.
- `ch_rdata`  out  DATA_W  read data, broadcast to all channels; valid with `ch_data_ok`.
- `m_req`, `m_wr`, `m_size[1:0]`, `m_addr[ADDR_W]`, `m_wdata[DATA_W]`  out  master request.
- `m_addr_ok`, `m_data_ok`  in  1  slave handshakes.
- `m_rdata`  in  DATA_W  slave read data.
- `busy`  out  1  at least one transaction is outstanding.
- `err_spurious`  out  1  sticky: `m_data_ok` arrived with no transaction outstanding.

## Operation
- Arbitration:
  - Candidates are channels with `ch_req`=1.
  - In mode 0 the lowest index wins.
  - In mode 1 the search starts at `rr_ptr`, wraps modulo CH_NUM and takes the first requester. After each accepted request, `rr_ptr` is set to grant+1, wrapping to 0 past CH_NUM-1.
- Grant lock:
  - Once `m_req`=1 with `m_addr_ok`=0, the grant is held in `lock_id` until acceptance.
  - `m_wr`, `m_size`, `m_addr` and `m_wdata` must be stable through that period.
  - A higher-priority request arriving meanwhile does not preempt.
- `m_req` = resetn & any candidate (or a locked request) & (!fifo_full | m_data_ok).
  - When the FIFO is full, a response in the same cycle frees a slot and permits acceptance.
- Acceptance: `m_req & m_addr_ok` pushes the granted ID into the ID FIFO, clears the lock and raises `ch_addr_ok[grant]` in the same cycle.
  - All other `ch_addr_ok` bits are 0.
- Response: `m_data_ok` with the FIFO non-empty pops the head ID and raises `ch_data_ok[head]`, with `ch_rdata` = `m_rdata`.
  - Push and pop in the same cycle leave the occupancy unchanged.
- Spurious response: `m_data_ok` with the FIFO empty is dropped (no `ch_data_ok`) and sets `err_spurious`, which clears only on reset.
- Channel contract: a channel holds `ch_req` and its request fields stable until it sees `ch_addr_ok`. Dropping `ch_req` while locked is a protocol violation; the lock holds regardless.
- Reset (`resetn`=0 at a clock edge):
  - FIFO, occupancy count, `rr_ptr`, lock and `err_spurious` are cleared.
  - `m_req` is forced to 0 combinationally while `resetn`=0.
  - Outstanding transactions are discarded; the slave must be reset with the CPU.

## Timing
- Reset values: `m_req` 0, `ch_addr_ok` 0, `ch_data_ok` 0, `busy` 0, `err_spurious` 0, `rr_ptr` 0, FIFO empty.
- Request path is combinational: `ch_req` to `m_req` and the `m_*` fields in zero cycles.
- `m_addr_ok` to `ch_addr_ok` is combinational, same cycle.
- `m_data_ok`/`m_rdata` to `ch_data_ok`/`ch_rdata` is combinational, same cycle.
- Registered state: FIFO, count, `rr_ptr`, `lock_valid`/`lock_id`, `err_spurious`.
- Back-to-back: one acceptance and one response per cycle are sustainable; throughput is 1 transaction/cycle.
- `busy` = (count != 0), taken from registered state.

## Structure
- Package `sram_like_pkg`:
  - size constants `SIZE_B`=2'd0, `SIZE_H`=2'd1, `SIZE_W`=2'd2;
  - `ARB_FIXED`=0, `ARB_RR`=1;
  - ID width function `$clog2(CH_NUM)`.
- Sub-module `id_fifo`: synchronous FIFO.
  - Width = ID width, depth = OUTSTANDING.
  - Pointers are one bit wider than the address for full/empty.
  - Outputs `full`, `empty`, `head`, `count`; supports simultaneous push/pop when full.
- The top contains the arbiter, lock register, muxes and error flag.

## Test plan
- Mode 0, ch0 and ch1 both requesting, `m_addr_ok`=1 every cycle -> ch0 accepted each cycle, ch1 starves; `ch_addr_ok`=2'b01.
- Mode 1, both channels requesting continuously -> grants alternate 0,1,0,1 and `rr_ptr` toggles.
- ch1 requests with `m_addr_ok` held 0 for 3 cycles, ch0 raises `ch_req` in cycle 2 -> `m_addr` stays at ch1's address and ch1 is accepted first.
- OUTSTANDING=4: accept 4 requests with no `m_data_ok` -> `m_req` drops. Then `m_data_ok` plus a pending request in the same cycle -> accepted, count stays 4.
- Issue IDs 1,0,1 then return three responses with `m_rdata` 0xA,0xB,0xC -> `ch_data_ok` sequence 10,01,10 with matching `ch_rdata`.
- `m_data_ok` while idle -> no `ch_data_ok`, `err_spurious`=1. Then `resetn`=0 for 1 cycle mid-transaction -> all outputs return to reset values.
